// File: rtl/vpu_wb_unit.sv
// VPU writeback: buffers up to MAX_BEATS result beats, drains them to SRAM on start, then pulses done.
// Optional perf counters under VPU_WB_PERF_CNT_EN; SRAM en/addr/data hold while ready is low.
module vpu_wb_unit #(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 16,
  parameter int ADDR_STRIDE = 1,
  parameter int MAX_BEATS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_data_valid_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              wb_start_i,
  input  logic [ADDR_W-1:0] wb_dst_addr_i,
  output logic              wb_done_o,
  output logic              sram_wr_en_o,
  output logic [ADDR_W-1:0] sram_wr_addr_o,
  output logic [DATA_W-1:0] sram_wr_data_o,
  input  logic              sram_wr_ready_i,
  output logic              busy_o,
  output logic              err_overflow_o,
  output logic              err_start_busy_o
`ifdef VPU_WB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_xfer_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] beat_buf [MAX_BEATS];
  logic [CNT_W-1:0]  count, idx, n_beats, n_start;
  logic [CNT_W:0]    n_sum;
  logic [ADDR_W-1:0] base;
  logic              capture, accept, last_beat;

  // A beat strobed together with start still counts toward the transfer length.
  always_comb begin
    n_sum   = {1'b0, count} + (CNT_W+1)'(wb_data_valid_i);
    n_start = (n_sum > (CNT_W+1)'(MAX_BEATS)) ? CNT_W'(MAX_BEATS) : n_sum[CNT_W-1:0];
  end

  assign capture   = (state == S_IDLE) && wb_data_valid_i && (count < CNT_W'(MAX_BEATS));
  assign accept    = (state == S_WRITE) && sram_wr_ready_i;
  assign last_beat = (idx == n_beats - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (wb_start_i) state_nxt = (n_start == '0) ? S_DONE : S_WRITE;
      S_WRITE: if (accept && last_beat) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address/data are forced to zero outside WRITE so idle outputs read as zero.
  always_comb begin
    wb_done_o      = 1'b0;
    sram_wr_en_o   = 1'b0;
    sram_wr_addr_o = '0;
    sram_wr_data_o = '0;
    busy_o         = (state != S_IDLE);
    case (state)
      S_WRITE: begin
        sram_wr_en_o   = 1'b1;
        sram_wr_addr_o = base + ADDR_W'(ADDR_STRIDE) * ADDR_W'(idx);
        sram_wr_data_o = beat_buf[idx[IDX_W-1:0]];
      end
      S_DONE:  wb_done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (capture) beat_buf[count[IDX_W-1:0]] <= wb_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count            <= '0;
      idx              <= '0;
      n_beats          <= '0;
      base             <= '0;
      err_overflow_o   <= 1'b0;
      err_start_busy_o <= 1'b0;
    end else begin
      if (capture) count <= count + CNT_W'(1);
      if (state == S_IDLE && wb_start_i) begin
        base    <= wb_dst_addr_i;
        n_beats <= n_start;
        idx     <= '0;
      end
      if (accept) idx <= idx + CNT_W'(1);
      if (state == S_DONE) count <= '0;
      if (wb_data_valid_i && !capture) err_overflow_o <= 1'b1;
      if (wb_start_i && state != S_IDLE) err_start_busy_o <= 1'b1;
    end
  end

`ifdef VPU_WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt_o <= '0;
      perf_xfer_cnt_o  <= '0;
    end else begin
      if (state == S_WRITE && !sram_wr_ready_i) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (state == S_DONE) perf_xfer_cnt_o <= perf_xfer_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vpu_wb_unit.sv
// Directed bench for vpu_wb_unit: hand-computed writes, done timing, error flags and wrap.
module tb_vpu_wb_unit;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_data_valid_i;
  logic [255:0] wb_data_i;
  logic         wb_start_i;
  logic [15:0]  wb_dst_addr_i;
  logic         wb_done_o;
  logic         sram_wr_en_o;
  logic [15:0]  sram_wr_addr_o;
  logic [255:0] sram_wr_data_o;
  logic         sram_wr_ready_i;
  logic         busy_o;
  logic         err_overflow_o;
  logic         err_start_busy_o;
`ifdef VPU_WB_PERF_CNT_EN
  logic [31:0]  perf_stall_cnt_o;
  logic [31:0]  perf_xfer_cnt_o;
`endif

  int n_pass = 0;
  int n_total = 0;

  vpu_wb_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_data_valid_i  (wb_data_valid_i),
    .wb_data_i        (wb_data_i),
    .wb_start_i       (wb_start_i),
    .wb_dst_addr_i    (wb_dst_addr_i),
    .wb_done_o        (wb_done_o),
    .sram_wr_en_o     (sram_wr_en_o),
    .sram_wr_addr_o   (sram_wr_addr_o),
    .sram_wr_data_o   (sram_wr_data_o),
    .sram_wr_ready_i  (sram_wr_ready_i),
    .busy_o           (busy_o),
    .err_overflow_o   (err_overflow_o),
    .err_start_busy_o (err_start_busy_o)
`ifdef VPU_WB_PERF_CNT_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_xfer_cnt_o  (perf_xfer_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1ns after the edge; inputs set then are taken at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_write(input string tag, input logic [15:0] a, input logic [255:0] d);
    chk({tag, "_en"},   sram_wr_en_o,   1'b1);
    chk({tag, "_addr"}, sram_wr_addr_o, a);
    chk({tag, "_data"}, sram_wr_data_o, d);
  endtask

  task automatic set_in(input logic v, input logic [255:0] d, input logic s, input logic [15:0] a);
    wb_data_valid_i = v;
    wb_data_i       = d;
    wb_start_i      = s;
    wb_dst_addr_i   = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    sram_wr_ready_i = 1'b1;
    set_in(1'b0, '0, 1'b0, '0);
    do_reset();

    // Reset state
    chk("rst_done", wb_done_o, 1'b0);
    chk("rst_en", sram_wr_en_o, 1'b0);
    chk("rst_addr", sram_wr_addr_o, 16'h0);
    chk("rst_data", sram_wr_data_o, 256'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ovf", err_overflow_o, 1'b0);
    chk("rst_sbusy", err_start_busy_o, 1'b0);

    // Two-beat op: beat A, idle cycle, then beat B with start
    set_in(1'b1, 256'hA, 1'b0, 16'h0); step();
    set_in(1'b0, 256'h0, 1'b0, 16'h0); step();
    set_in(1'b1, 256'hB, 1'b1, 16'h0100); step();
    set_in(1'b0, 256'h0, 1'b0, 16'h0);
    chk_write("two_w0", 16'h0100, 256'hA);
    chk("two_busy", busy_o, 1'b1);
    step();
    chk_write("two_w1", 16'h0101, 256'hB);
    step();
    chk("two_done", wb_done_o, 1'b1);
    chk("two_done_en", sram_wr_en_o, 1'b0);
    step();
    chk("two_done_pulse", wb_done_o, 1'b0);
    chk("two_idle", busy_o, 1'b0);
    chk("two_ovf", err_overflow_o, 1'b0);
    chk("two_sbusy", err_start_busy_o, 1'b0);

    // Single-beat op
    set_in(1'b1, 256'h5, 1'b1, 16'h0020); step();
    set_in(1'b0, 256'h0, 1'b0, 16'h0);
    chk_write("one_w0", 16'h0020, 256'h5);
    step();
    chk("one_done", wb_done_o, 1'b1);
    step();
    chk("one_after", wb_done_o, 1'b0);
    chk("one_en_after", sram_wr_en_o, 1'b0);

    // Backpressure: three stalled cycles, then both beats accepted
    do_reset();
    sram_wr_ready_i = 1'b0;
    set_in(1'b1, 256'h11, 1'b0, 16'h0); step();
    set_in(1'b1, 256'h22, 1'b1, 16'h0040); step();
    set_in(1'b0, 256'h0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk_write($sformatf("bp_stall%0d", i), 16'h0040, 256'h11);
      step();
    end
    sram_wr_ready_i = 1'b1;
    chk_write("bp_w0", 16'h0040, 256'h11);
    step();
    chk_write("bp_w1", 16'h0041, 256'h22);
    step();
    chk("bp_done", wb_done_o, 1'b1);
    step();
    chk("bp_done_pulse", wb_done_o, 1'b0);
`ifdef VPU_WB_PERF_CNT_EN
    chk("bp_perf_stall", perf_stall_cnt_o, 32'd3);
    chk("bp_perf_xfer", perf_xfer_cnt_o, 32'd1);
`endif

    // Overflow: third beat dropped
    set_in(1'b1, 256'h1, 1'b0, 16'h0); step();
    set_in(1'b1, 256'h2, 1'b0, 16'h0); step();
    chk("ovf_before", err_overflow_o, 1'b0);
    set_in(1'b1, 256'h3, 1'b0, 16'h0); step();
    chk("ovf_set", err_overflow_o, 1'b1);
    set_in(1'b0, 256'h0, 1'b1, 16'h0000); step();
    set_in(1'b0, 256'h0, 1'b0, 16'h0);
    chk_write("ovf_w0", 16'h0000, 256'h1);
    step();
    chk_write("ovf_w1", 16'h0001, 256'h2);
    step();
    chk("ovf_done", wb_done_o, 1'b1);
    chk("ovf_sticky", err_overflow_o, 1'b1);
    step();

    // Zero beats: done next cycle, no write
    set_in(1'b0, 256'h0, 1'b1, 16'h0050); step();
    set_in(1'b0, 256'h0, 1'b0, 16'h0);
    chk("zero_done", wb_done_o, 1'b1);
    chk("zero_en", sram_wr_en_o, 1'b0);
    step();
    chk("zero_after", wb_done_o, 1'b0);
    chk("zero_en_after", sram_wr_en_o, 1'b0);

    // Start while busy is ignored and flagged
    sram_wr_ready_i = 1'b0;
    set_in(1'b1, 256'h77, 1'b1, 16'h0060); step();
    chk("sb_before", err_start_busy_o, 1'b0);
    set_in(1'b0, 256'h0, 1'b1, 16'h0099); step();
    set_in(1'b0, 256'h0, 1'b0, 16'h0);
    chk("sb_flag", err_start_busy_o, 1'b1);
    chk_write("sb_hold", 16'h0060, 256'h77);
    sram_wr_ready_i = 1'b1;
    step();
    chk("sb_done", wb_done_o, 1'b1);
    step();
    chk("sb_idle", busy_o, 1'b0);

    // Reset mid-WRITE abandons transfer and clears flags
    sram_wr_ready_i = 1'b0;
    set_in(1'b1, 256'hC, 1'b1, 16'h0010); step();
    set_in(1'b0, 256'h0, 1'b0, 16'h0);
    chk("mr_en_pre", sram_wr_en_o, 1'b1);
    rst_n = 1'b0; step();
    chk("mr_en", sram_wr_en_o, 1'b0);
    chk("mr_addr", sram_wr_addr_o, 16'h0);
    chk("mr_data", sram_wr_data_o, 256'h0);
    chk("mr_done", wb_done_o, 1'b0);
    chk("mr_busy", busy_o, 1'b0);
    chk("mr_ovf", err_overflow_o, 1'b0);
    chk("mr_sbusy", err_start_busy_o, 1'b0);
    rst_n = 1'b1;
    sram_wr_ready_i = 1'b1;
    step();
    chk("mr_nodone", wb_done_o, 1'b0);
    chk("mr_noen", sram_wr_en_o, 1'b0);

    // Address wrap from 0xFFFF
    set_in(1'b1, 256'hE, 1'b0, 16'h0); step();
    set_in(1'b1, 256'hF, 1'b1, 16'hFFFF); step();
    set_in(1'b0, 256'h0, 1'b0, 16'h0);
    chk_write("wrap_w0", 16'hFFFF, 256'hE);
    step();
    chk_write("wrap_w1", 16'h0000, 256'hF);
    step();
    chk("wrap_done", wb_done_o, 1'b1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vpu_wb_unit.md
Name: vpu_wb_unit

Overview:
Writeback stage downstream of the VPU controller/execution datapath. Captures up to two result beats flagged by the controller's write-back data-valid strobe. On write-back start it drains them to the SRAM write port with a valid/ready handshake, then pulses done back to the controller. The controller's S_WB state waits on this done pulse.

Parameters:
DATA_W, 256, width of one result beat / SRAM write word
ADDR_W, 16, SRAM word address width
ADDR_STRIDE, 1, address increment between consecutive beats
MAX_BEATS, 2, buffer depth in beats (fixed by EXEC_1/EXEC_2 sequencing)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wb_data_valid_i  in  1  one-cycle strobe; capture wb_data_i this cycle
wb_data_i  in  DATA_W  result beat from execution unit
wb_start_i  in  1  one-cycle strobe; begin draining buffered beats
wb_dst_addr_i  in  ADDR_W  destination base address, sampled with wb_start_i
wb_done_o  out  1  one-cycle pulse when all beats are written
sram_wr_en_o  out  1  write request valid
sram_wr_addr_o  out  ADDR_W  write address
sram_wr_data_o  out  DATA_W  write data
sram_wr_ready_i  in  1  SRAM accepts the write when en&ready
busy_o  out  1  high in WRITE or DONE
err_overflow_o  out  1  sticky: beat arrived with buffer full
err_start_busy_o  out  1  sticky: wb_start_i while busy

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge) forces the following:
  - state=IDLE; buffer count=0; beat index=0.
  - All outputs 0: wb_done_o, sram_wr_en_o, sram_wr_addr_o, sram_wr_data_o, busy_o, and both error flags.
  - Reset mid-WRITE abandons the transfer. No done pulse is issued.
- Capture buffer: 2 entries, filled in order, entry = count.
  - wb_data_valid_i with count<MAX_BEATS: store the beat, count++.
  - wb_data_valid_i with count==MAX_BEATS: drop the beat, set err_overflow_o.
  - Capture is allowed only in IDLE. A valid in WRITE/DONE is dropped and sets err_overflow_o.
- Same-cycle valid+start is required behaviour (the controller's EXEC_2 asserts both).
  - The beat presented that cycle is included in the transfer.
  - n_beats = count + wb_data_valid_i, saturated at MAX_BEATS. Saturation sets overflow.
- FSM IDLE:
  - On wb_start_i: latch base=wb_dst_addr_i and n_beats; idx=0.
  - n_beats==0 -> DONE (no SRAM writes). Otherwise -> WRITE.
- FSM WRITE:
  - sram_wr_en_o=1, sram_wr_addr_o=base+idx*ADDR_STRIDE (mod 2^ADDR_W, wraps silently), sram_wr_data_o=buf[idx].
  - Address, data and en stay stable while ready=0.
  - On en&ready: idx++. If idx==n_beats-1 -> DONE.
- FSM DONE: wb_done_o=1 for exactly one cycle; count=0; -> IDLE.
- wb_start_i in WRITE/DONE: ignored, sets err_start_busy_o.
- Latency with ready tied high: start at cycle T -> writes at T+1 (and T+2 for 2 beats) -> done at T+2 (1 beat) or T+3 (2 beats). Zero beats -> done at T+1.
- Outputs are registered/state-decoded. No combinational path from wb_start_i to sram_wr_en_o.
- Error flags clear only on reset.

Optional Feature:
Macro VPU_WB_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt_o[31:0] (cycles in WRITE with en&!ready) and perf_xfer_cnt_o[31:0] (completed transfers, incremented on wb_done_o).
  - Both are free-running, wrap at 2^32, and reset to 0.
- Undefined: ports and counters absent. Functional behaviour is identical.

Test Plan:
- Two-beat EXEC op: valid with D0=0xA at T0; valid+start with D1=0xB, addr=0x0100 at T2; ready=1 -> writes (0x0100,0xA) at T3 and (0x0101,0xB) at T4; done at T5; no error flags.
- Single-beat op: valid+start with D=0x5, addr=0x0020, ready=1 -> one write (0x0020,0x5) the next cycle; done one cycle later.
- Backpressure: two beats buffered, ready low for 3 cycles, then high -> en, addr and data held constant during the stall; writes then complete in order; done follows the last accept. With VPU_WB_PERF_CNT_EN: stall=3, xfer=1.
- Overflow: three valids (0x1,0x2,0x3) then start at addr 0 -> only 0x1 and 0x2 written; err_overflow_o=1.
- Zero beats and busy start: start with an empty buffer -> done the next cycle, no sram_wr_en_o. A second start issued during a WRITE -> ignored; err_start_busy_o=1.
- Reset and wrap: assert rst_n=0 mid-WRITE -> all outputs 0 next cycle, no done. Then base=0xFFFF, 2 beats -> writes to 0xFFFF then 0x0000.
